// File: rtl/nn_pkg.sv
// Shared requantisation package: word widths, FSM encoding and the round/shift/saturate helper.
// Other requantising stages import this so rounding behaviour stays identical across the engine.
package nn_pkg;

  localparam int ACC_W  = 32;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Round-half-up, arithmetic shift, saturate. One extra bit keeps the rounding add from wrapping.
  function automatic logic signed [DATA_W-1:0] sat_round(input logic signed [ACC_W-1:0] acc,
                                                         input int shift);
    logic signed [ACC_W:0] t;
    logic signed [ACC_W:0] q;
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    t  = {acc[ACC_W-1], acc} + ((ACC_W+1)'(1) << (shift - 1));
    q  = t >>> shift;
    hi = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = ~hi;
    if (q > hi)
      return hi[DATA_W-1:0];
    else if (q < lo)
      return lo[DATA_W-1:0];
    else
      return q[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/output_writer_fifo.sv
// Small synchronous result FIFO, first-word-through (dout shows the head word while non-empty).
// Latency: a word pushed at edge N can be popped at edge N+1.
// Backpressure: full/empty flags only; push when full and pop when empty are dropped.
module result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign dout  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[PW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/output_writer.sv
// Requantises accumulator sums to DATA_W words and writes NUM_OUT of them sequentially to the output RAM.
// Latency: a sum accepted at edge N is on the dom write port after edge N+1; one word per cycle sustained.
// Backpressure: res_ready drops while the FIFO is full or all NUM_OUT words of the run are accepted.
module output_writer
  import nn_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int NUM_OUT    = 8,
  parameter int FRAC_SHIFT = 8,
  parameter int RELU_EN    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [ACC_W-1:0]  res_data,
  output logic [ADDR_W-1:0] dut__dom__address,
  output logic [DATA_W-1:0] dut__dom__data,
  output logic              dut__dom__enable,
  output logic              dut__dom__write,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;

  state_t                    state;
  logic [CNT_W-1:0]          acc_cnt;
  logic [CNT_W-1:0]          wr_cnt;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_clr;
  logic [DATA_W-1:0]         fifo_dout;
  logic signed [DATA_W-1:0]  sat_word;
  logic [DATA_W-1:0]         q_word;

  assign sat_word = sat_round(res_data, FRAC_SHIFT);
  assign q_word   = ((RELU_EN != 0) && sat_word[DATA_W-1]) ? '0 : sat_word;

  // Ready depends only on registered state, so there is no combinational path from the pop side.
  assign res_ready = (state == ST_RUN) && !fifo_full && (acc_cnt < CNT_W'(NUM_OUT));
  assign fifo_push = res_valid && res_ready;
  assign fifo_pop  = (state == ST_RUN) && !fifo_empty && (wr_cnt < CNT_W'(NUM_OUT));
  assign fifo_clr  = (state == ST_IDLE) && start;

  result_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (q_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      acc_cnt           <= '0;
      wr_cnt            <= '0;
      dut__dom__address <= '0;
      dut__dom__data    <= '0;
      dut__dom__enable  <= 1'b0;
      dut__dom__write   <= 1'b0;
      done              <= 1'b0;
    end else begin
      dut__dom__enable <= 1'b0;
      dut__dom__write  <= 1'b0;
      done             <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            acc_cnt <= '0;
            wr_cnt  <= '0;
          end
        end
        ST_RUN: begin
          if (fifo_push)
            acc_cnt <= acc_cnt + 1'b1;
          if (fifo_pop) begin
            dut__dom__enable  <= 1'b1;
            dut__dom__write   <= 1'b1;
            dut__dom__address <= wr_cnt[ADDR_W-1:0];
            dut__dom__data    <= fifo_dout;
            wr_cnt            <= wr_cnt + 1'b1;
          end
          if (wr_cnt == CNT_W'(NUM_OUT)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
